rover_cpu_oci_trace_capture: RTL
================================

ROVER_CPU_OCI_TRACE_CAPTURE -- requirements
Module: rover_cpu_oci_trace_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 30, meaning the trace word width.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the trace count field width.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the FIFO entry count (power of 2, >=2).
REQ-004 The block SHALL have parameter OVF_MODE, default 0, meaning full-write policy (0 = drop newest, 1 = overwrite oldest).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port dct_valid, input, 1 bit: the trace word is presented this cycle.
REQ-008 The block SHALL have port dct_buffer, input, DATA_W bits: the trace word.
REQ-009 The block SHALL have port dct_count, input, CNT_W bits: the valid-slot count in dct_buffer.
REQ-010 The block SHALL have port test_ending, input, 1 bit: the end-of-test request (level or pulse).
REQ-011 The block SHALL have port rd_ready, input, 1 bit: the consumer accepts rd_data.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: the FIFO is non-empty.
REQ-013 The block SHALL have port rd_data, output, CNT_W+DATA_W bits: {count, word} of the oldest entry.
REQ-014 The block SHALL have port level, output, log2(DEPTH)+1 bits: the current occupancy.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, set on any lost entry.
REQ-016 The block SHALL have port drop_count, output, 16 bits: the count of lost entries, saturating.
REQ-017 The block SHALL have port test_has_ended, output, 1 bit: the drain is complete, held until reset.

Function
REQ-018 The write SHALL be accepted only when state==CAPTURE, dct_valid==1 and dct_count!=0; dct_count==0 words SHALL be discarded silently (no drop_count, no overflow).
REQ-019 Read handshake SHALL be rd_valid && rd_ready; rd_data SHALL be show-ahead (oldest entry, combinational from storage), and a read SHALL advance the read pointer at the clock edge.
REQ-020 A written entry SHALL appear on rd_valid/rd_data in the cycle after the write edge (1-cycle latency); an empty FIFO SHALL never pass a write through in the same cycle.
REQ-021 level SHALL update on the edge: +1 on write only, -1 on read only, unchanged on simultaneous write and read; pointers SHALL wrap modulo DEPTH.
REQ-022 A write while full with a simultaneous read SHALL succeed with no loss in either OVF_MODE.
REQ-023 In OVF_MODE=0, a write while full without a read SHALL be discarded, overflow SHALL set, and drop_count SHALL increment.
REQ-024 In OVF_MODE=1, a write while full without a read SHALL overwrite the oldest entry, advance the read pointer, keep level=DEPTH, set overflow, and increment drop_count.
REQ-025 drop_count SHALL saturate at 16'hFFFF; overflow SHALL clear only on reset.
REQ-026 The state machine SHALL have the states CAPTURE, DRAIN and DONE.
REQ-027 CAPTURE->DRAIN SHALL occur on test_ending==1, and a write presented in the same cycle SHALL still be accepted.
REQ-028 In DRAIN, writes SHALL be ignored (not counted as drops) and reads SHALL continue.
REQ-029 DRAIN->DONE SHALL occur on the edge where level==0, or level==1 with a read handshake.
REQ-030 DONE SHALL be terminal until reset: test_has_ended=1, writes ignored, test_ending ignored.
REQ-031 test_ending in DRAIN or DONE SHALL have no effect.

Reset
REQ-032 Assertion of reset_n=0 SHALL asynchronously clear the pointers, level, overflow, drop_count and test_has_ended, and set state=CAPTURE; rd_valid SHALL be 0 and rd_data don't-care (storage not reset).
REQ-033 Reset mid-DRAIN or mid-DONE SHALL discard all contents and return to CAPTURE; release SHALL be synchronised by the integrating system, and the first write SHALL be accepted on the first edge after release.

Verification
REQ-034 Bench: 3 writes (count=4, words 0x1,0x2,0x3) with rd_ready=0 -> level=3, rd_data={4,0x1}; then rd_ready=1 for 3 cycles -> 0x1,0x2,0x3 in order, then rd_valid=0.
REQ-035 Bench: OVF_MODE=0, DEPTH=16, 18 writes with no reads -> level=16, entries 1..16 read back, overflow=1, drop_count=2.
REQ-036 Bench: OVF_MODE=1, same stimulus -> level=16, entries 3..18 read back, drop_count=2.
REQ-037 Bench: full FIFO with simultaneous write and read each cycle for 10 cycles -> level stays 16, drop_count=0, no gap in the sequence.
REQ-038 Bench: 5 entries, test_ending with a concurrent write, rd_ready=1 -> 6 entries read, then test_has_ended=1 on the edge of the last read; later dct_valid ignored, drop_count unchanged.
REQ-039 Bench: empty FIFO, test_ending pulse -> test_has_ended=1 two edges later; reset_n low mid-DRAIN -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/rover_cpu_oci_trace_capture.sv
// rtl/rover_cpu_oci_trace_capture.sv - trace capture FIFO with end-of-test drain sequencing
//
// Captures {dct_count, dct_buffer} trace words into a DEPTH-entry FIFO while
// in CAPTURE, stops accepting on test_ending, lets the consumer drain the FIFO,
// then raises test_has_ended until reset.
//
// Ports:
//   clk, reset_n            clock (rising edge) and asynchronous active-low reset
//   dct_valid/buffer/count  trace word input; count==0 words are discarded silently
//   test_ending             end-of-test request (level or pulse), honoured in CAPTURE only
//   rd_ready                consumer accepts rd_data this cycle
//   rd_valid, rd_data       show-ahead head of the FIFO, {count, word}
//   level                   current occupancy (0..DEPTH)
//   overflow, drop_count    sticky loss flag and saturating lost-entry counter
//   test_has_ended          drain complete, held until reset
module rover_cpu_oci_trace_capture #(
    parameter int DATA_W   = 30,
    parameter int CNT_W    = 4,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       dct_valid,
    input  logic [DATA_W-1:0]          dct_buffer,
    input  logic [CNT_W-1:0]           dct_count,
    input  logic                       test_ending,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [CNT_W+DATA_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic                       test_has_ended
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int LEVEL_W = ADDR_W + 1;
    localparam bit OVERWRITE = (OVF_MODE != 0);

    typedef enum logic [1:0] {
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W+DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;

    logic wr_req;
    logic rd_fire;
    logic full;
    logic wr_ok;
    logic lost;
    logic ovw;
    logic mem_we;

    assign rd_valid = (level != '0);
    assign rd_data  = mem[rd_ptr];
    assign full     = (level == LEVEL_W'(DEPTH));
    assign rd_fire  = rd_valid && rd_ready;

    assign wr_req   = (state == CAPTURE) && dct_valid && (dct_count != '0);
    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr_ok    = wr_req && (!full || rd_fire);
    assign lost     = wr_req && full && !rd_fire;
    // Overwrite mode: wr_ptr == rd_ptr when full, so writing there replaces the oldest entry.
    assign ovw      = lost && OVERWRITE;
    assign mem_we   = wr_ok || ovw;

    assign test_has_ended = (state == DONE);

    // Storage is deliberately not reset; rd_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= {dct_count, dct_buffer};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_fire || ovw) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (wr_ok && !rd_fire) begin
                level <= level + LEVEL_W'(1);
            end else if (!wr_ok && rd_fire) begin
                level <= level - LEVEL_W'(1);
            end
            if (lost) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CAPTURE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CAPTURE: begin
                if (test_ending) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Finish on the edge that empties the FIFO, or immediately if already empty.
                if ((level == '0) || ((level == LEVEL_W'(1)) && rd_fire)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = CAPTURE;
            end
        endcase
    end

endmodule
